// File: rtl/control_sequencer_pkg.sv
// Shared types for the 8-bit core control path: ALU ops, opcodes, sequencer states,
// register-write sources and instruction field positions.
package control_sequencer_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_MUL = 4'd2,
    ALU_DIV = 4'd3,
    ALU_AND = 4'd4,
    ALU_OR  = 4'd5,
    ALU_XOR = 4'd6,
    ALU_NOT = 4'd7,
    ALU_SHL = 4'd8,
    ALU_SHR = 4'd9,
    ALU_ROL = 4'd10,
    ALU_ROR = 4'd11
  } alu_op_e;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_ADD   = 4'h1,
    OP_SUB   = 4'h2,
    OP_MUL   = 4'h3,
    OP_DIV   = 4'h4,
    OP_AND   = 4'h5,
    OP_OR    = 4'h6,
    OP_XOR   = 4'h7,
    OP_NOT   = 4'h8,
    OP_SHIFT = 4'h9,
    OP_ROT   = 4'hA,
    OP_MOV   = 4'hB,
    OP_LDI   = 4'hC,
    OP_JMP   = 4'hD,
    OP_RSV   = 4'hE,
    OP_HLT   = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    FETCH_A,
    FETCH_M,
    DECODE,
    EXEC,
    WB,
    IMM_A,
    IMM_M,
    HALT
  } seq_state_e;

  typedef enum logic [1:0] {
    WSRC_ALU = 2'd0,
    WSRC_BUS = 2'd1,
    WSRC_REG = 2'd2
  } reg_wsrc_e;

  localparam int unsigned OPC_MSB = 7;
  localparam int unsigned OPC_LSB = 4;
  localparam int unsigned DST_MSB = 3;
  localparam int unsigned DST_LSB = 2;
  localparam int unsigned SRC_MSB = 1;
  localparam int unsigned SRC_LSB = 0;

endpackage

// File: rtl/control_sequencer_if.sv
// Memory-bus / ALU / register-file control bundle driven by the sequencer.
// master = sequencer side, slave = datapath/memory side.
interface control_sequencer_if #(
  parameter int unsigned NREG_W   = 2,
  parameter int unsigned RETIRE_W = 16
) ();
  import control_sequencer_pkg::*;

  logic [7:0]          bus_in;
  logic                mem_ready;
  logic                pc_out_en;
  logic                mar_load;
  logic                mem_out_en;
  logic                pc_inc;
  logic                pc_load;
  logic [NREG_W-1:0]   reg_sel1;
  logic [NREG_W-1:0]   reg_sel2;
  alu_op_e             alu_op;
  logic                alu_out;
  logic                reg_we;
  logic [NREG_W-1:0]   reg_wsel;
  logic [1:0]          reg_wsrc;
  logic                halted;
  logic                illegal;
  logic [RETIRE_W-1:0] retired;

  modport master (
    input  bus_in, mem_ready,
    output pc_out_en, mar_load, mem_out_en, pc_inc, pc_load,
           reg_sel1, reg_sel2, alu_op, alu_out,
           reg_we, reg_wsel, reg_wsrc, halted, illegal, retired
  );

  modport slave (
    output bus_in, mem_ready,
    input  pc_out_en, mar_load, mem_out_en, pc_inc, pc_load,
           reg_sel1, reg_sel2, alu_op, alu_out,
           reg_we, reg_wsel, reg_wsrc, halted, illegal, retired
  );

endinterface

// File: rtl/control_sequencer_op_decode.sv
// Combinational instruction decode: IR byte -> opcode, ALU op, operand fields and class flags.
module control_sequencer_op_decode import control_sequencer_pkg::*; #(
  parameter int unsigned NREG_W = 2
) (
  input  logic [7:0]        i_ir,
  output opcode_e           o_opcode,
  output alu_op_e           o_alu_op,
  output logic [NREG_W-1:0] o_dst,
  output logic [NREG_W-1:0] o_src,
  output logic              o_needs_imm,
  output logic              o_is_alu
);

  opcode_e w_opcode;

  assign w_opcode = opcode_e'(i_ir[OPC_MSB:OPC_LSB]);
  assign o_opcode = w_opcode;
  assign o_dst    = NREG_W'(i_ir[DST_MSB:DST_LSB]);
  assign o_src    = NREG_W'(i_ir[SRC_MSB:SRC_LSB]);

  always_comb begin
    o_alu_op    = ALU_ADD;
    o_needs_imm = 1'b0;
    o_is_alu    = 1'b1;
    case (w_opcode)
      OP_ADD:   o_alu_op = ALU_ADD;
      OP_SUB:   o_alu_op = ALU_SUB;
      OP_MUL:   o_alu_op = ALU_MUL;
      OP_DIV:   o_alu_op = ALU_DIV;
      OP_AND:   o_alu_op = ALU_AND;
      OP_OR:    o_alu_op = ALU_OR;
      OP_XOR:   o_alu_op = ALU_XOR;
      OP_NOT:   o_alu_op = ALU_NOT;
      // Direction comes from the raw src field bit 0, independent of NREG_W.
      OP_SHIFT: o_alu_op = i_ir[SRC_LSB] ? ALU_SHR : ALU_SHL;
      OP_ROT:   o_alu_op = i_ir[SRC_LSB] ? ALU_ROR : ALU_ROL;
      OP_LDI, OP_JMP: begin
        o_is_alu    = 1'b0;
        o_needs_imm = 1'b1;
      end
      default:  o_is_alu = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer for the 8-bit core; sole source of ALU control.
// Define CTRL_ILLEGAL_TRAP_EN to make the reserved opcode halt instead of retiring as a NOP.
module control_sequencer import control_sequencer_pkg::*; #(
  parameter int unsigned NREG_W   = 2,
  parameter int unsigned RETIRE_W = 16
) (
  input  logic                clock,
  input  logic                reset,
  control_sequencer_if.master bus
);

  seq_state_e          r_state;
  seq_state_e          w_next;
  logic [7:0]          r_ir;
  alu_op_e             r_alu_op;
  logic                r_illegal;
  logic [RETIRE_W-1:0] r_retired;

  opcode_e             w_opcode;
  alu_op_e             w_alu_op;
  logic [NREG_W-1:0]   w_dst;
  logic [NREG_W-1:0]   w_src;
  logic                w_needs_imm;
  logic                w_is_alu;
  logic                w_retire;
  logic                w_set_illegal;

  control_sequencer_op_decode #(.NREG_W(NREG_W)) u_op_decode (
    .i_ir        (r_ir),
    .o_opcode    (w_opcode),
    .o_alu_op    (w_alu_op),
    .o_dst       (w_dst),
    .o_src       (w_src),
    .o_needs_imm (w_needs_imm),
    .o_is_alu    (w_is_alu)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= FETCH_A;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_retire      = 1'b0;
    w_set_illegal = 1'b0;
    case (r_state)
      FETCH_A: w_next = FETCH_M;
      FETCH_M: if (bus.mem_ready) w_next = DECODE;
      DECODE: begin
        if (w_opcode == OP_NOP) begin
          w_next   = FETCH_A;
          w_retire = 1'b1;
        end else if (w_opcode == OP_HLT) begin
          w_next   = HALT;
          w_retire = 1'b1;
        end else if (w_opcode == OP_RSV) begin
          w_set_illegal = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
          w_next        = HALT;
`else
          w_next        = FETCH_A;
          w_retire      = 1'b1;
`endif
        end else if (w_opcode == OP_MOV) begin
          w_next = WB;
        end else if (w_needs_imm) begin
          w_next = IMM_A;
        end else begin
          w_next = EXEC;
        end
      end
      EXEC: w_next = WB;
      WB: begin
        w_next   = FETCH_A;
        w_retire = 1'b1;
      end
      IMM_A: w_next = IMM_M;
      IMM_M: begin
        if (bus.mem_ready) begin
          w_next   = FETCH_A;
          w_retire = 1'b1;
        end
      end
      HALT:    w_next = HALT;
      default: w_next = FETCH_A;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ir      <= '0;
      r_alu_op  <= ALU_ADD;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      if (r_state == FETCH_M && bus.mem_ready) r_ir <= bus.bus_in;
      if (r_state == DECODE && w_is_alu)        r_alu_op <= w_alu_op;
      if (w_set_illegal)                        r_illegal <= 1'b1;
      if (w_retire)                             r_retired <= r_retired + RETIRE_W'(1);
    end
  end

  assign bus.alu_op  = r_alu_op;
  assign bus.illegal = r_illegal;
  assign bus.retired = r_retired;

  // Strobes are forced idle while reset is held so nothing fires before the first fetch.
  always_comb begin
    bus.pc_out_en  = 1'b0;
    bus.mar_load   = 1'b0;
    bus.mem_out_en = 1'b0;
    bus.pc_inc     = 1'b0;
    bus.pc_load    = 1'b0;
    bus.reg_sel1   = '0;
    bus.reg_sel2   = '0;
    bus.alu_out    = 1'b0;
    bus.reg_we     = 1'b0;
    bus.reg_wsel   = '0;
    bus.reg_wsrc   = WSRC_ALU;
    bus.halted     = 1'b0;
    if (!reset) begin
      case (r_state)
        FETCH_A, IMM_A: begin
          bus.pc_out_en = 1'b1;
          bus.mar_load  = 1'b1;
        end
        FETCH_M: begin
          bus.mem_out_en = 1'b1;
          bus.pc_inc     = bus.mem_ready;
        end
        EXEC: begin
          bus.reg_sel1 = w_dst;
          bus.reg_sel2 = w_src;
        end
        WB: begin
          bus.reg_we   = 1'b1;
          bus.reg_wsel = w_dst;
          if (w_is_alu) begin
            bus.alu_out  = 1'b1;
            bus.reg_wsrc = WSRC_ALU;
          end else begin
            bus.reg_wsrc = WSRC_REG;
            bus.reg_sel2 = w_src;
          end
        end
        IMM_M: begin
          bus.mem_out_en = 1'b1;
          if (bus.mem_ready) begin
            if (w_opcode == OP_LDI) begin
              bus.reg_we   = 1'b1;
              bus.reg_wsrc = WSRC_BUS;
              bus.reg_wsel = w_dst;
              bus.pc_inc   = 1'b1;
            end else begin
              bus.pc_load  = 1'b1;
            end
          end
        end
        HALT:    bus.halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
